// File: rtl/in_stage_loader.sv
// FFT input frame buffer: stores a frame in natural order, drains it by address.
// Define IN_BITREV_EN to write at bit-reversed addresses (DIT input ordering).
module in_stage_loader #(
    parameter int bit_width = 24,
    parameter int N         = 16,
    parameter int SIZE      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_i,
    input  logic signed [bit_width-1:0] Re_i,
    input  logic signed [bit_width-1:0] Im_i,
    output logic                        ready_o,
    input  logic                        en_i,
    output logic signed [bit_width-1:0] Re_o,
    output logic signed [bit_width-1:0] Im_o,
    output logic [SIZE-1:0]             index_o,
    output logic                        valid_o,
    output logic                        start_o,
    output logic                        done_o,
    output logic                        overflow_o
);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [SIZE-1:0] LAST = SIZE'(N - 1);

    state_t                     state, state_nx;
    logic [SIZE-1:0]            wr_cnt, wr_cnt_nx;
    logic [SIZE-1:0]            rd_cnt, rd_cnt_nx;
    logic [SIZE-1:0]            wr_addr;
    logic                       wr_en, rd_en, start_nx;
    logic                       start_q, valid_q, ovf_q;
    logic [SIZE-1:0]            index_q;
    logic [2*bit_width-1:0]     rd_data;
    logic [2*bit_width-1:0]     mem [N];

`ifdef IN_BITREV_EN
    function automatic logic [SIZE-1:0] bitrev(input logic [SIZE-1:0] a);
        logic [SIZE-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            r[i] = a[SIZE-1-i];
        end
        return r;
    endfunction

    assign wr_addr = bitrev(wr_cnt);
`else
    assign wr_addr = wr_cnt;
`endif

    always_comb begin
        state_nx  = state;
        wr_cnt_nx = wr_cnt;
        rd_cnt_nx = rd_cnt;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        start_nx  = 1'b0;
        case (state)
            FILL: begin
                if (valid_i) begin
                    wr_en = 1'b1;
                    if (wr_cnt == LAST) begin
                        wr_cnt_nx = '0;
                        state_nx  = DRAIN;
                        start_nx  = 1'b1;
                    end else begin
                        wr_cnt_nx = wr_cnt + SIZE'(1);
                    end
                end
            end
            DRAIN: begin
                if (en_i) begin
                    rd_en = 1'b1;
                    if (rd_cnt == LAST) begin
                        rd_cnt_nx = '0;
                        state_nx  = FILL;
                    end else begin
                        rd_cnt_nx = rd_cnt + SIZE'(1);
                    end
                end
            end
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            index_q <= '0;
            rd_data <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            wr_cnt  <= wr_cnt_nx;
            rd_cnt  <= rd_cnt_nx;
            start_q <= start_nx;
            valid_q <= rd_en;
            if (rd_en) begin
                index_q <= rd_cnt;
                rd_data <= mem[rd_cnt];
            end
            // Samples offered outside FILL are dropped; the flag stays until reset.
            if (valid_i && (state == DRAIN)) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage array has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_addr] <= {Re_i, Im_i};
        end
    end

    assign ready_o    = (state == FILL);
    assign start_o    = start_q;
    assign valid_o    = valid_q;
    assign index_o    = index_q;
    assign Re_o       = rd_data[2*bit_width-1:bit_width];
    assign Im_o       = rd_data[bit_width-1:0];
    assign done_o     = valid_q && (index_q == LAST);
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_in_stage_loader.sv
// Directed bench for in_stage_loader (N=16): frame order, stalls, gaps, overflow, resets.
module tb_in_stage_loader;

    localparam int BW   = 24;
    localparam int N    = 16;
    localparam int SIZE = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 valid_i;
    logic signed [BW-1:0] Re_i, Im_i;
    logic                 ready_o;
    logic                 en_i;
    logic signed [BW-1:0] Re_o, Im_o;
    logic [SIZE-1:0]      index_o;
    logic                 valid_o, start_o, done_o, overflow_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic signed [BW-1:0] re_in;
        logic signed [BW-1:0] im_in;
        logic [SIZE-1:0]      exp_idx;
        logic signed [BW-1:0] exp_re;
        logic signed [BW-1:0] exp_im;
    } vec_t;

    vec_t vec[N];
    int   br_order[N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    in_stage_loader #(
        .bit_width(BW),
        .N(N),
        .SIZE(SIZE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .valid_i(valid_i),
        .Re_i(Re_i),
        .Im_i(Im_i),
        .ready_o(ready_o),
        .en_i(en_i),
        .Re_o(Re_o),
        .Im_o(Im_o),
        .index_o(index_o),
        .valid_o(valid_o),
        .start_o(start_o),
        .done_o(done_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_frame(input bit gaps);
        for (int j = 0; j < N; j++) begin
            valid_i = 1'b1;
            Re_i    = vec[j].re_in;
            Im_i    = vec[j].im_in;
            step();
            if (j == N - 2) begin
                check("ready_before_last", 64'(ready_o), 64'd1);
                check("no_early_start", 64'(start_o), 64'd0);
            end
            if (gaps && j < N - 1) begin
                valid_i = 1'b0;
                Re_i    = 24'h7fffff;
                Im_i    = 24'h7fffff;
                step();
            end
        end
        valid_i = 1'b0;
        check("start_after_last_write", 64'(start_o), 64'd1);
        check("ready_low_in_drain", 64'(ready_o), 64'd0);
    endtask

    // mode 0: en_i held high; mode 1: 5 idle cycles then en_i toggling
    task automatic collect(input int mode);
        int   cnt;
        logic prev_en;
        cnt = 0;
        for (int c = 0; c < 80 && cnt < N; c++) begin
            if (mode == 0) prev_en = 1'b1;
            else           prev_en = (c >= 5) && (((c - 5) % 2) == 0);
            en_i = prev_en;
            step();
            check("start_single_pulse", 64'(start_o), 64'd0);
            check("valid_follows_en", 64'(valid_o), 64'(prev_en));
            if (valid_o) begin
                check("index", 64'(index_o), 64'(vec[cnt].exp_idx));
                check("re", 64'(Re_o), 64'(vec[cnt].exp_re));
                check("im", 64'(Im_o), 64'(vec[cnt].exp_im));
                check("done", 64'(done_o), 64'(cnt == N - 1));
                if (cnt == N - 1) check("ready_on_done", 64'(ready_o), 64'd1);
                cnt++;
            end
        end
        en_i = 1'b0;
        check("out_count", 64'(cnt), 64'(N));
    endtask

    initial begin
        int k;
        int st[3];
        int starts, oc, wk;

        rst = 1'b1; valid_i = 1'b0; en_i = 1'b0; Re_i = '0; Im_i = '0;

        for (int j = 0; j < N; j++) begin
`ifdef IN_BITREV_EN
            k = br_order[j];
`else
            k = j;
`endif
            vec[j].re_in   = 24'(j);
            vec[j].im_in   = 24'(-j);
            vec[j].exp_idx = 4'(j);
            vec[j].exp_re  = 24'(k);
            vec[j].exp_im  = 24'(-k);
        end

        // reset state
        step(); step();
        rst = 1'b0;
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_start", 64'(start_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_overflow", 64'(overflow_o), 64'd0);
        check("rst_re", 64'(Re_o), 64'd0);
        check("rst_im", 64'(Im_o), 64'd0);
        check("rst_index", 64'(index_o), 64'd0);

        // basic frame, continuous en_i
        write_frame(1'b0);
        collect(0);

        // stalled drain
        write_frame(1'b0);
        collect(1);
        check("no_overflow_yet", 64'(overflow_o), 64'd0);

        // input gaps, then a dropped sample during DRAIN
        write_frame(1'b1);
        valid_i = 1'b1; Re_i = 24'd999; Im_i = 24'd999;
        step();
        valid_i = 1'b0;
        check("overflow_set", 64'(overflow_o), 64'd1);
        check("still_drain", 64'(ready_o), 64'd0);
        collect(0);
        check("overflow_sticky", 64'(overflow_o), 64'd1);

        // reset after 7 writes, then a full new frame
        for (int j = 0; j < 7; j++) begin
            valid_i = 1'b1; Re_i = 24'(100 + j); Im_i = 24'(200 + j);
            step();
        end
        valid_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("overflow_cleared", 64'(overflow_o), 64'd0);
        check("ready_after_rst", 64'(ready_o), 64'd1);
        write_frame(1'b0);
        collect(0);

        // reset mid-DRAIN
        write_frame(1'b0);
        en_i = 1'b1;
        for (int j = 0; j < 4; j++) step();
        check("mid_drain_valid", 64'(valid_o), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        en_i = 1'b0;
        check("drain_rst_valid", 64'(valid_o), 64'd0);
        check("drain_rst_ready", 64'(ready_o), 64'd1);
        check("drain_rst_index", 64'(index_o), 64'd0);
        write_frame(1'b0);
        collect(0);

        // back-to-back frames, source follows ready_o
        starts = 0; oc = 0; wk = 0;
        st[0] = 0; st[1] = 0; st[2] = 0;
        for (int c = 0; c < 150 && starts < 3; c++) begin
            valid_i = ready_o;
            if (ready_o) begin
                Re_i = vec[wk].re_in;
                Im_i = vec[wk].im_in;
                wk = (wk + 1) % N;
            end
            en_i = 1'b1;
            step();
            if (start_o) begin
                st[starts] = c;
                starts++;
            end
            if (valid_o) begin
                check("b2b_index", 64'(index_o), 64'(vec[oc % N].exp_idx));
                check("b2b_re", 64'(Re_o), 64'(vec[oc % N].exp_re));
                check("b2b_done", 64'(done_o), 64'((oc % N) == N - 1));
                if (done_o) check("b2b_accept_on_done", 64'(ready_o), 64'd1);
                oc++;
            end
        end
        valid_i = 1'b0;
        en_i = 1'b0;
        check("b2b_starts", 64'(starts), 64'd3);
        check("b2b_period1", 64'(st[1] - st[0]), 64'd32);
        check("b2b_period2", 64'(st[2] - st[1]), 64'd32);
        check("b2b_outputs", 64'(oc), 64'd32);
        check("b2b_no_overflow", 64'(overflow_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/in_stage_loader.md
# in_stage_loader

Input-side frame buffer for the parallel decimation-in-time FFT. It is the counterpart of the output stage: that stage writes results at bit-reversed addresses and reads them back in natural order. This block accepts a frame of N complex samples in natural order and stores each one at its bit-reversed address. It then streams the frame out in natural address order to the first butterfly stage. A one-cycle `start_o` pulse launches the FFT pipeline.

## Interface
Parameters:
- `bit_width`, 24: width of each signed Re/Im sample.
- `N`, 16: frame length in complex samples; must be a power of two.
- `SIZE`, 4: address width; equals log2(N).

Ports (clock and reset first):
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `valid_i` input 1: input sample is present this cycle.
- `Re_i` input bit_width: signed real part of the input sample.
- `Im_i` input bit_width: signed imaginary part of the input sample.
- `ready_o` output 1: the block can accept a sample (FILL state).
- `en_i` input 1: downstream read enable, level-sensitive; one read per cycle while high.
- `Re_o` output bit_width: signed real part of the output sample.
- `Im_o` output bit_width: signed imaginary part of the output sample.
- `index_o` output SIZE: RAM address of the current output sample.
- `valid_o` output 1: `Re_o`, `Im_o` and `index_o` are valid.
- `start_o` output 1: one-cycle pulse when a full frame is buffered.
- `done_o` output 1: one-cycle pulse coincident with the last `valid_o` of a frame.
- `overflow_o` output 1: sticky flag; set when a sample arrives while the block is not ready.

## Operation
- Storage: one N x (2·bit_width) RAM with a registered read port (1-cycle latency). There is a write counter `wr_cnt` and a read counter `rd_cnt`, each SIZE bits wide.
- FILL state (reset state):
  - `ready_o` = 1.
  - Each cycle with `valid_i`=1 writes {`Re_i`,`Im_i`} to address `bitrev(wr_cnt)`, then increments `wr_cnt`.
  - Gaps in `valid_i` are allowed; the counter holds.
  - The write with `wr_cnt`=N-1 moves the block to DRAIN and clears `wr_cnt` to 0.
- DRAIN state:
  - `ready_o` = 0.
  - `start_o` is 1 during the first DRAIN cycle only.
  - Each cycle with `en_i`=1 reads address `rd_cnt`, captures `rd_cnt` for `index_o`, and increments `rd_cnt`.
  - `en_i`=0 freezes `rd_cnt`. No read is issued, and `valid_o` is 0 in the following cycle.
  - The read of address N-1 moves the block to FILL and clears `rd_cnt` to 0.
- Output register: `valid_o`, `index_o`, `Re_o` and `Im_o` appear the cycle after the read is issued.
  - `done_o` = `valid_o` AND (`index_o` == N-1).
- Overflow: `valid_i`=1 while `ready_o`=0 drops the sample and sets `overflow_o`. `overflow_o` is cleared only by `rst`.
- Reads and writes never target the RAM in the same cycle. The last read issues in DRAIN; the first write of the next frame is in FILL.
- No arithmetic is performed; samples pass through unchanged and without sign extension.

## Timing
- Reset values:
  - `ready_o`=1 (the block is in FILL).
  - `valid_o`, `start_o`, `done_o` and `overflow_o` = 0.
  - `Re_o`, `Im_o` and `index_o` = 0.
  - Both counters = 0.
- RAM contents are not reset.
- A reset asserted in any cycle, including mid-FILL or mid-DRAIN, aborts the frame. The cycle after `rst` deasserts is FILL with `wr_cnt`=0.
- Latency:
  - Last input write in cycle t.
  - `start_o` in cycle t+1.
  - First read no earlier than t+1, if `en_i` is high.
  - First `valid_o` at t+2 at the earliest.
- Minimum frame period is 2N cycles with continuous `valid_i` and `en_i`.
- `ready_o` returns to 1 in the same cycle that the last output data is registered, so `done_o` and the first accepted sample of the next frame can coincide.

## Configuration
- `IN_BITREV_EN` defined: the write address is `bitrev(wr_cnt)`, so the output is the frame in bit-reversed order, as the DIT butterflies require.
- `IN_BITREV_EN` undefined: the write address is `wr_cnt`, so the output is the frame in natural order. Use this for the classical (non-reordering) FFT variant and for loop-back tests.
- No other behaviour changes with the macro.

## Test plan
- Basic bit-reverse (`IN_BITREV_EN` defined, N=16):
  - Stimulus: Re_i=k, Im_i=-k for k=0..15 on 16 consecutive cycles; `en_i` held at 1.
  - Response: `start_o` one cycle after the 16th write.
  - Output k in order 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 at `index_o`=0..15.
  - `done_o` with `index_o`=15.
- Macro undefined: same stimulus gives output k = `index_o` = 0..15 in order.
- Stall:
  - Stimulus: hold `en_i` at 0 for 5 cycles after `start_o`, then toggle it every other cycle.
  - Response: `valid_o` only in cycles following `en_i`=1, with no skipped or duplicated index; 16 outputs total.
- Input gaps and overflow:
  - Stimulus: `valid_i` with gaps during FILL; then one `valid_i` during DRAIN.
  - Response: the frame is correct; the DRAIN sample is dropped; `overflow_o`=1 and stays set until `rst`.
- Reset mid-operation:
  - Stimulus: `rst` after 7 writes; then a full new frame.
  - Response: outputs contain only the new frame; `start_o` after the new 16th write.
  - Stimulus: `rst` mid-DRAIN.
  - Response: `valid_o`=0 the next cycle; `ready_o`=1.
- Back-to-back frames:
  - Stimulus: continuous `valid_i`, `en_i`=1.
  - Response: a new frame is accepted in the `done_o` cycle; period is 32 cycles; no overflow.
